// File: rtl/geiger_harness_pkg.sv
// geiger_harness_pkg: constants and types shared by the Geiger test-harness stack/unstack blocks.
`default_nettype none
package geiger_harness_pkg;
    localparam int BYTES_PER_WORD = 6;
    localparam int CHUNK_W        = 8;
    localparam int GEIGER_WORD_W  = BYTES_PER_WORD * CHUNK_W;

    typedef logic [GEIGER_WORD_W-1:0] geiger_word_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } unstack_state_t;
endpackage
`default_nettype wire

// File: rtl/geiger_gap_timer.sv
// geiger_gap_timer: saturating idle-cycle counter; o_timeout flags the GAP_MAX-th consecutive enabled cycle.
`default_nettype none
module geiger_gap_timer #(
    parameter int GAP_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);
    localparam int CNT_W = $clog2(GAP_MAX + 1);

    logic [CNT_W-1:0] r_count;

    assign o_timeout = i_en && !i_clr && (r_count >= CNT_W'(GAP_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_W'(GAP_MAX))) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/test_harness_geiger_unstack.sv
// test_harness_geiger_unstack: reassembles LSB-first 8-bit chunks into the 48-bit Geiger stack word.
`default_nettype none
module test_harness_geiger_unstack
    import geiger_harness_pkg::*;
#(
    parameter int BYTES   = BYTES_PER_WORD,
    parameter int WORD_W  = GEIGER_WORD_W,
    parameter int GAP_MAX = 16
) (
    input  logic              CLK_1MHZ,
    input  logic              RESET,
    input  logic [7:0]        D_IN,
    input  logic              D_VALID,
    input  logic              D_SOF,
    output logic [WORD_W-1:0] GEIGER_DATA,
    output logic              DATA_READY,
    output logic              FRAME_ERR,
    output logic [2:0]        BYTE_CNT
);
    unstack_state_t    r_state, w_state_nxt;
    logic [WORD_W-1:0] r_asm, w_asm_nxt;
    logic [WORD_W-1:0] r_data, w_data_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_err, w_err_nxt;
    logic              w_gap_clr, w_gap_en, w_timeout;

    assign w_gap_clr = (r_state == ST_IDLE) || D_VALID;
    assign w_gap_en  = (r_state == ST_COLLECT) && !D_VALID;

    geiger_gap_timer #(
        .GAP_MAX (GAP_MAX)
    ) u_gap_timer (
        .clk       (CLK_1MHZ),
        .rst_n     (RESET),
        .i_clr     (w_gap_clr),
        .i_en      (w_gap_en),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_asm_nxt   = r_asm;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (D_VALID) begin
                    w_asm_nxt   = WORD_W'(D_IN);
                    w_cnt_nxt   = 3'd1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (D_VALID && D_SOF) begin
                    // Resync: the SOF chunk restarts the frame as chunk 0.
                    w_err_nxt = 1'b1;
                    w_asm_nxt = WORD_W'(D_IN);
                    w_cnt_nxt = 3'd1;
                end else if (D_VALID) begin
                    w_asm_nxt[r_cnt*CHUNK_W +: CHUNK_W] = D_IN;
                    if (r_cnt == 3'(BYTES - 1)) begin
                        w_data_nxt  = w_asm_nxt;
                        w_ready_nxt = 1'b1;
                        w_asm_nxt   = '0;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_asm_nxt   = '0;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_asm_nxt   = '0;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_asm   <= '0;
            r_data  <= '0;
            r_cnt   <= 3'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_asm   <= w_asm_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign GEIGER_DATA = r_data;
    assign DATA_READY  = r_ready;
    assign FRAME_ERR   = r_err;
    assign BYTE_CNT    = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_test_harness_geiger_unstack.sv
// tb_test_harness_geiger_unstack: directed plus random chunk streams checked by a queue-based reference model.
`default_nettype none
module tb_test_harness_geiger_unstack;
    logic        CLK_1MHZ = 1'b0;
    logic        RESET    = 1'b0;
    logic [7:0]  D_IN     = 8'h00;
    logic        D_VALID  = 1'b0;
    logic        D_SOF    = 1'b0;
    logic [47:0] GEIGER_DATA;
    logic        DATA_READY;
    logic        FRAME_ERR;
    logic [2:0]  BYTE_CNT;

    test_harness_geiger_unstack dut (
        .CLK_1MHZ    (CLK_1MHZ),
        .RESET       (RESET),
        .D_IN        (D_IN),
        .D_VALID     (D_VALID),
        .D_SOF       (D_SOF),
        .GEIGER_DATA (GEIGER_DATA),
        .DATA_READY  (DATA_READY),
        .FRAME_ERR   (FRAME_ERR),
        .BYTE_CNT    (BYTE_CNT)
    );

    always #5 CLK_1MHZ = ~CLK_1MHZ;

    typedef struct {
        bit          is_err;
        logic [47:0] word;
        int          stamp;
    } ev_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    ev_t         evq[$];
    logic [7:0]  fq[$];
    int          idle_run = 0;
    logic [47:0] exp_word = '0;
    int          exp_cnt  = 0;

    always @(posedge CLK_1MHZ) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a frame is simply the list of chunks received so far.
    task automatic model(input bit v, input bit sof, input logic [7:0] d);
        ev_t e;
        logic [47:0] w;
        if (!RESET) return;
        if (v) begin
            idle_run = 0;
            if (sof && fq.size() > 0) begin
                e.is_err = 1'b1; e.word = '0; e.stamp = cyc;
                evq.push_back(e);
                fq.delete();
            end
            fq.push_back(d);
            if (fq.size() == 6) begin
                w = '0;
                for (int i = 0; i < 6; i++) w = w | (48'(fq[i]) << (8 * i));
                exp_word = w;
                e.is_err = 1'b0; e.word = w; e.stamp = cyc;
                evq.push_back(e);
                fq.delete();
            end
        end else if (fq.size() > 0) begin
            idle_run++;
            if (idle_run == 16) begin
                e.is_err = 1'b1; e.word = '0; e.stamp = cyc;
                evq.push_back(e);
                fq.delete();
                idle_run = 0;
            end
        end
        exp_cnt = fq.size();
    endtask

    task automatic step(input bit v, input bit sof, input logic [7:0] d);
        D_VALID = v;
        D_SOF   = sof;
        D_IN    = v ? d : 8'($urandom);
        @(posedge CLK_1MHZ);
        #1;
        model(v, sof, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [47:0] w, input int gap);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i == 0, w[8*i +: 8]);
            if (i < 5) idle(gap);
        end
    endtask

    // Monitor: every pulse must match the head of the expected-event queue in kind, cycle and word.
    always @(negedge CLK_1MHZ) begin
        if (RESET) begin
            chk("byte_cnt", 64'(BYTE_CNT), 64'(exp_cnt));
            chk("geiger_data_hold", 64'(GEIGER_DATA), 64'(exp_word));
            if (DATA_READY && FRAME_ERR) chk("pulse_exclusive", 64'(FRAME_ERR), 64'(0));
            while (evq.size() > 0 && evq[0].stamp < cyc) begin
                chk("missed_pulse_cycle", 64'(cyc), 64'(evq[0].stamp));
                void'(evq.pop_front());
            end
            if (DATA_READY || FRAME_ERR) begin
                if (evq.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, DATA_READY, FRAME_ERR}, 64'(0));
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("pulse_kind_err", 64'(FRAME_ERR), 64'(e.is_err));
                    chk("pulse_cycle", 64'(cyc), 64'(e.stamp));
                    if (!e.is_err) chk("ready_word", 64'(GEIGER_DATA), 64'(e.word));
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge CLK_1MHZ);
        #1;
        chk("reset_data",  64'(GEIGER_DATA), 64'(0));
        chk("reset_ready", 64'(DATA_READY),  64'(0));
        chk("reset_err",   64'(FRAME_ERR),   64'(0));
        chk("reset_cnt",   64'(BYTE_CNT),    64'(0));
        RESET = 1'b1;
        idle(2);

        send(48'h0123456789AB, 0);  idle(3);
        send(48'h0123456789AB, 10); idle(3);

        for (int i = 0; i < 3; i++) step(1'b1, i == 0, 8'(8'h50 + i));
        idle(18);
        send(48'hFFEEDDCCBBAA, 0);  idle(3);

        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 8'(8'hA0 + i));
        send(48'h665544332211, 0);  idle(3);

        send(48'h0123456789AB, 0);
        send(48'h0000000000FF, 0);  idle(3);

        for (int i = 0; i < 3; i++) step(1'b1, i == 0, 8'(8'h70 + i));
        #2;
        RESET = 1'b0;
        fq.delete(); idle_run = 0; exp_word = '0; exp_cnt = 0;
        #1;
        chk("async_reset_data",  64'(GEIGER_DATA), 64'(0));
        chk("async_reset_cnt",   64'(BYTE_CNT),    64'(0));
        chk("async_reset_err",   64'(FRAME_ERR),   64'(0));
        chk("async_reset_ready", 64'(DATA_READY),  64'(0));
        idle(2);
        RESET = 1'b1;
        idle(1);
        send(48'h123456ABCDEF, 0);  idle(3);

        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60)      step(1'b1, $urandom_range(0, 9) == 0, 8'($urandom));
            else if (r < 95) step(1'b0, 1'($urandom), 8'h00);
            else             idle(int'($urandom_range(10, 20)));
        end
        idle(20);
        chk("event_queue_drained", 64'(evq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
